// File: rtl/cpu_feeder_pkg.sv
// Shared types and constants for the cpu instruction feeder.
// State encoding, status-flag bit positions and the default datapath width.
package cpu_feeder_pkg;

  localparam int CPU_IW = 16;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/cpu_feeder_fifo.sv
// Generic synchronous FIFO with occupancy count and sticky overflow flag.
// Latency: a push into an empty FIFO is visible at head_dat the next cycle.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module cpu_feeder_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_instr_feeder.sv
// Feeds queued instructions to the cpu over load/s/w and captures out + N/V/Z.
// Latency: 4 cycles + cpu execution time per instruction; optional CPU_FEEDER_WATCHDOG_EN.
// Backpressure: FIFO drops pushes when full (sticky overflow); issue waits on cpu_w.
module cpu_instr_feeder
  import cpu_feeder_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int IW      = CPU_IW,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [IW-1:0]          push_instr,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   cpu_w,
  input  logic [IW-1:0]          cpu_out,
  input  logic                   cpu_N,
  input  logic                   cpu_V,
  input  logic                   cpu_Z,
  output logic [IW-1:0]          cpu_in,
  output logic                   cpu_load,
  output logic                   cpu_s,
  output logic                   busy,
  output logic                   res_valid,
  output logic [IW-1:0]          res_data,
  output logic [2:0]             res_flags
`ifdef CPU_FEEDER_WATCHDOG_EN
  ,output logic                  wd_err
`endif
);

  if (DEPTH < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("cpu_instr_feeder: DEPTH must be >= 2 and TIMEOUT >= 1");
  end

  feeder_state_e state;
  feeder_state_e state_nxt;
  logic [IW-1:0] head;
  logic          pop;
  logic          wd_abort;

  cpu_feeder_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_instr),
    .pop      (pop),
    .head_dat (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

`ifdef CPU_FEEDER_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wd_cnt;

  assign wd_abort = (state == START || state == RUN) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (state == LOAD)                        wd_cnt <= '0;
      else if (state == START || state == RUN)  wd_cnt <= wd_cnt + WDW'(1);
      if (wd_abort) wd_err <= 1'b1;
    end
  end
`else
  assign wd_abort = 1'b0;
`endif

  // The head entry stays in the FIFO until its instruction retires or is abandoned.
  assign pop = (state == DONE) || wd_abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty && cpu_w) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   if (!cpu_w) state_nxt = RUN;
      RUN:     if (cpu_w) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (wd_abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cpu_in    <= '0;
      cpu_load  <= 1'b0;
      cpu_s     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      cpu_load  <= (state == IDLE) && (state_nxt == LOAD);
      cpu_s     <= (state_nxt == START);
      res_valid <= (state == RUN) && (state_nxt == DONE);
      if (state == IDLE && state_nxt == LOAD) cpu_in <= head;
      // Capture on the edge that samples cpu_w high so data aligns with res_valid.
      if (state == RUN && state_nxt == DONE) begin
        res_data          <= cpu_out;
        res_flags[FLAG_N] <= cpu_N;
        res_flags[FLAG_V] <= cpu_V;
        res_flags[FLAG_Z] <= cpu_Z;
      end
    end
  end

endmodule
